// File: rtl/stepper_phase_decoder_pkg.sv
// Shared definitions for the stepper phase decoder: coil patterns, index
// decoding and the per-cycle event classification.
package stepper_pkg;

  localparam int IDX_W = 3;

  // Phase patterns ordered {A+, B+, A-, B-}; index increases clockwise.
  localparam logic [3:0] PH_IDLE = 4'b0000;
  localparam logic [3:0] PH_I0   = 4'b1000;
  localparam logic [3:0] PH_I1   = 4'b1100;
  localparam logic [3:0] PH_I2   = 4'b0100;
  localparam logic [3:0] PH_I3   = 4'b0110;
  localparam logic [3:0] PH_I4   = 4'b0010;
  localparam logic [3:0] PH_I5   = 4'b0011;
  localparam logic [3:0] PH_I6   = 4'b0001;
  localparam logic [3:0] PH_I7   = 4'b1001;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } ph_dec_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_LOAD,
    EV_CW,
    EV_CCW,
    EV_BADPAT,
    EV_JUMP
  } step_ev_e;

  function automatic ph_dec_t ph2idx(input logic [3:0] ph);
    ph_dec_t res;
    res.vld = 1'b1;
    res.idx = '0;
    case (ph)
      PH_I0:   res.idx = 3'd0;
      PH_I1:   res.idx = 3'd1;
      PH_I2:   res.idx = 3'd2;
      PH_I3:   res.idx = 3'd3;
      PH_I4:   res.idx = 3'd4;
      PH_I5:   res.idx = 3'd5;
      PH_I6:   res.idx = 3'd6;
      PH_I7:   res.idx = 3'd7;
      default: res.vld = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stepper_phase_decoder_phase_sync.sv
// Two-flop synchronizer bank for asynchronous coil sense lines.
module phase_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         xres,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge xres) begin
    if (!xres) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Decodes the four coil drive lines into half-step position, direction,
// step period and stall/error status.
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int          POS_W     = 16,
  parameter int          PER_W     = 24,
  parameter int unsigned STALL_CNT = 24'd5000000
) (
  input  logic                    clk,
  input  logic                    xres,
  input  logic                    ph_ap,
  input  logic                    ph_bp,
  input  logic                    ph_an,
  input  logic                    ph_bn,
  input  logic                    clr,
  output logic signed [POS_W-1:0] pos,
  output logic                    dir,
  output logic                    step_pulse,
  output logic        [PER_W-1:0] period,
  output logic                    period_vld,
  output logic                    stalled,
  output logic                    err
);

  localparam logic [PER_W-1:0] STALL_LIM = PER_W'(STALL_CNT);

  logic [3:0] ph_raw;
  logic [3:0] ph_s;

  assign ph_raw = {ph_ap, ph_bp, ph_an, ph_bn};

  phase_sync #(.W(4)) u_sync (
    .clk  (clk),
    .xres (xres),
    .d_i  (ph_raw),
    .q_o  (ph_s)
  );

  logic                    ref_vld_q, ref_vld_d;
  logic [IDX_W-1:0]        ref_idx_q, ref_idx_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic                    dir_q, dir_d;
  logic                    step_q, step_d;
  logic                    err_q, err_d;
  logic [PER_W-1:0]        cnt_q, cnt_d;
  logic [PER_W-1:0]        period_q, period_d;
  logic                    period_vld_q, period_vld_d;
  logic                    have_prev_q, have_prev_d;
  logic                    stalled_q, stalled_d;

  ph_dec_t          dec;
  step_ev_e         ev;
  logic [IDX_W-1:0] delta;
  logic [IDX_W-1:0] step_mag;
  logic [POS_W-1:0] step_ext;
  logic [PER_W-1:0] cnt_inc;

  assign dec   = ph2idx(ph_s);
  assign delta = dec.idx - ref_idx_q;

  always_comb begin
    ev = EV_NONE;
    if (ph_s == PH_IDLE) begin
      ev = EV_NONE;
    end else if (!dec.vld) begin
      ev = EV_BADPAT;
    end else if (!ref_vld_q) begin
      ev = EV_LOAD;
    end else if (dec.idx != ref_idx_q) begin
      case (delta)
        3'd1, 3'd2: ev = EV_CW;
        3'd6, 3'd7: ev = EV_CCW;
        default:    ev = EV_JUMP;
      endcase
    end
  end

  // A ccw move of (8 - d) half-steps equals -d in 3-bit arithmetic.
  assign step_mag = (ev == EV_CCW) ? (-delta) : delta;
  assign step_ext = POS_W'(step_mag);

  always_comb begin
    ref_vld_d = ref_vld_q;
    ref_idx_d = ref_idx_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    err_d     = err_q;
    case (ev)
      EV_LOAD: begin
        ref_vld_d = 1'b1;
        ref_idx_d = dec.idx;
      end
      EV_CW: begin
        ref_idx_d = dec.idx;
        pos_d     = pos_q + step_ext;
        dir_d     = DIR_CW;
        step_d    = 1'b1;
      end
      EV_CCW: begin
        ref_idx_d = dec.idx;
        pos_d     = pos_q - step_ext;
        dir_d     = DIR_CCW;
        step_d    = 1'b1;
      end
      EV_JUMP: begin
        ref_idx_d = dec.idx;
      end
      default: begin
      end
    endcase
    if (clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end
    // A fault in the same cycle as clr must not be lost.
    if (ev == EV_BADPAT || ev == EV_JUMP) begin
      err_d = 1'b1;
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : (cnt_q + PER_W'(1));

  always_comb begin
    cnt_d        = cnt_inc;
    period_d     = period_q;
    period_vld_d = 1'b0;
    have_prev_d  = have_prev_q;
    stalled_d    = stalled_q;
    if (step_d) begin
      if (have_prev_q) begin
        period_d     = cnt_inc;
        period_vld_d = 1'b1;
      end
      cnt_d       = '0;
      have_prev_d = 1'b1;
      stalled_d   = 1'b0;
    end else if (cnt_q >= STALL_LIM) begin
      stalled_d   = 1'b1;
      have_prev_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge xres) begin
    if (!xres) begin
      ref_vld_q    <= 1'b0;
      ref_idx_q    <= '0;
      pos_q        <= '0;
      dir_q        <= DIR_CW;
      step_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      have_prev_q  <= 1'b0;
      stalled_q    <= 1'b1;
    end else begin
      ref_vld_q    <= ref_vld_d;
      ref_idx_q    <= ref_idx_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      have_prev_q  <= have_prev_d;
      stalled_q    <= stalled_d;
    end
  end

  assign pos        = pos_q;
  assign dir        = dir_q;
  assign step_pulse = step_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign stalled    = stalled_q;
  assign err        = err_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed bench for stepper_phase_decoder with hand-computed expectations.
module tb_stepper_phase_decoder;

  localparam int POS_W = 8;
  localparam int PER_W = 24;

  logic             clk = 1'b0;
  logic             xres = 1'b1;
  logic             ph_ap = 1'b0, ph_bp = 1'b0, ph_an = 1'b0, ph_bn = 1'b0;
  logic             clr = 1'b0;
  logic [POS_W-1:0] pos;
  logic             dir, step_pulse, period_vld, stalled, err;
  logic [PER_W-1:0] period;

  stepper_phase_decoder #(
    .POS_W     (POS_W),
    .PER_W     (PER_W),
    .STALL_CNT (200)
  ) dut (
    .clk        (clk),
    .xres       (xres),
    .ph_ap      (ph_ap),
    .ph_bp      (ph_bp),
    .ph_an      (ph_an),
    .ph_bn      (ph_bn),
    .clr        (clr),
    .pos        (pos),
    .dir        (dir),
    .step_pulse (step_pulse),
    .period     (period),
    .period_vld (period_vld),
    .stalled    (stalled),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_step = 0;
  int n_pv = 0;
  int s0, p0;

  always @(negedge clk) begin
    if (step_pulse) n_step <= n_step + 1;
    if (period_vld) n_pv <= n_pv + 1;
  end

  function automatic logic [3:0] pat(input int i);
    case (i)
      0: return 4'b1000;
      1: return 4'b1100;
      2: return 4'b0100;
      3: return 4'b0110;
      4: return 4'b0010;
      5: return 4'b0011;
      6: return 4'b0001;
      default: return 4'b1001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
    $display("chk %-22s got %0h want %0h", tag, got, want);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] p);
    {ph_ap, ph_bp, ph_an, ph_bn} = p;
  endtask

  task automatic apply(input logic [3:0] p, input int n);
    drive(p);
    tick(n);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
  endtask

  initial begin
    #1 xres = 1'b0;
    drive(4'b0000);
    tick(3);
    chk("rst_pos", 32'(pos), 32'h0);
    chk("rst_dir", 32'(dir), 32'h1);
    chk("rst_step", 32'(step_pulse), 32'h0);
    chk("rst_period", 32'(period), 32'h0);
    chk("rst_pvld", 32'(period_vld), 32'h0);
    chk("rst_stalled", 32'(stalled), 32'h1);
    chk("rst_err", 32'(err), 32'h0);
    xres = 1'b1;
    tick(2);

    // 2-phase cw, 100 clk per pattern
    apply(4'b1100, 100);
    chk("t1_ref_load_pos", 32'(pos), 32'h0);
    chk("t1_ref_load_steps", 32'(n_step), 32'h0);
    s0 = n_step;
    p0 = n_pv;
    drive(4'b0110);
    tick(2);
    chk("t1_latency_pre", 32'(step_pulse), 32'h0);
    tick(1);
    chk("t1_latency_step", 32'(step_pulse), 32'h1);
    chk("t1_pos_first", 32'(pos), 32'h2);
    chk("t1_stall_clear", 32'(stalled), 32'h0);
    tick(97);
    apply(4'b0011, 100);
    apply(4'b1001, 100);
    apply(4'b1100, 100);
    chk("t1_pos", 32'(pos), 32'h8);
    chk("t1_dir", 32'(dir), 32'h1);
    chk("t1_steps", 32'(n_step - s0), 32'd4);
    chk("t1_pvlds", 32'(n_pv - p0), 32'd3);
    chk("t1_period", 32'(period), 32'd100);
    chk("t1_err", 32'(err), 32'h0);

    // 1-2 phase ccw from a fresh reset
    drive(4'b0000);
    xres = 1'b0;
    tick(2);
    xres = 1'b1;
    tick(2);
    s0 = n_step;
    p0 = n_pv;
    apply(4'b1000, 50);
    chk("t2_ref_load_pos", 32'(pos), 32'h0);
    apply(4'b1001, 50);
    apply(4'b0001, 50);
    apply(4'b0011, 50);
    chk("t2_pos", 32'(pos), 32'hFD);
    chk("t2_dir", 32'(dir), 32'h0);
    chk("t2_period", 32'(period), 32'd50);
    chk("t2_steps", 32'(n_step - s0), 32'd3);
    chk("t2_pvlds", 32'(n_pv - p0), 32'd2);

    // illegal pattern, illegal jump, clr and idle retention
    s0 = n_step;
    apply(4'b1010, 10);
    chk("t3_badpat_err", 32'(err), 32'h1);
    chk("t3_badpat_pos", 32'(pos), 32'hFD);
    chk("t3_badpat_steps", 32'(n_step - s0), 32'h0);
    apply(4'b0000, 5);
    pulse_clr();
    chk("t3_clr_err", 32'(err), 32'h0);
    chk("t3_clr_pos", 32'(pos), 32'h0);
    apply(4'b0001, 10);
    apply(4'b1000, 10);
    chk("t3_pre_jump_pos", 32'(pos), 32'h3);
    s0 = n_step;
    apply(4'b0010, 10);
    chk("t3_jump_err", 32'(err), 32'h1);
    chk("t3_jump_steps", 32'(n_step - s0), 32'h0);
    chk("t3_jump_pos", 32'(pos), 32'h3);
    apply(4'b0000, 5);
    pulse_clr();
    chk("t3_clr2_err", 32'(err), 32'h0);
    apply(4'b0000, 20);
    apply(4'b0011, 10);
    chk("t3_idle_keep_ref", 32'(pos), 32'h1);

    // stall at 200 cycles, then restart of period measurement
    drive(4'b0001);
    tick(203);
    chk("t4_stall_early", 32'(stalled), 32'h0);
    tick(1);
    chk("t4_stall_set", 32'(stalled), 32'h1);
    tick(46);
    drive(4'b1001);
    tick(3);
    chk("t4_restart_step", 32'(step_pulse), 32'h1);
    chk("t4_restart_stall", 32'(stalled), 32'h0);
    chk("t4_restart_pvld", 32'(period_vld), 32'h0);
    tick(27);
    drive(4'b1000);
    tick(3);
    chk("t4_period_vld", 32'(period_vld), 32'h1);
    chk("t4_period", 32'(period), 32'd30);
    tick(7);

    // wrap at +127 and clr coincident with a step / an illegal pattern
    pulse_clr();
    for (int i = 1; i <= 63; i++) apply(pat((2 * i) % 8), 5);
    chk("t5_pos_126", 32'(pos), 32'd126);
    apply(pat(7), 5);
    chk("t5_pos_max", 32'(pos), 32'h7F);
    apply(pat(0), 5);
    chk("t5_pos_wrap", 32'(pos), 32'h80);
    drive(pat(1));
    tick(2);
    clr = 1'b1;
    tick(1);
    chk("t5_clr_step_pulse", 32'(step_pulse), 32'h1);
    chk("t5_clr_step_pos", 32'(pos), 32'h0);
    chk("t5_clr_step_pvld", 32'(period_vld), 32'h1);
    chk("t5_clr_step_period", 32'(period), 32'd5);
    clr = 1'b0;
    tick(4);
    drive(4'b1111);
    tick(2);
    clr = 1'b1;
    tick(1);
    chk("t5_clr_vs_illegal", 32'(err), 32'h1);
    clr = 1'b0;
    apply(4'b0000, 5);

    // asynchronous reset between steps
    apply(pat(0), 10);
    chk("t6_pre_dir", 32'(dir), 32'h0);
    chk("t6_pre_pos", 32'(pos), 32'hFF);
    #2 xres = 1'b0;
    #1;
    chk("t6_rst_pos", 32'(pos), 32'h0);
    chk("t6_rst_dir", 32'(dir), 32'h1);
    chk("t6_rst_err", 32'(err), 32'h0);
    chk("t6_rst_stalled", 32'(stalled), 32'h1);
    chk("t6_rst_period", 32'(period), 32'h0);
    drive(pat(3));
    tick(2);
    xres = 1'b1;
    s0 = n_step;
    tick(10);
    chk("t6_first_no_step", 32'(n_step - s0), 32'h0);
    chk("t6_first_pos", 32'(pos), 32'h0);
    apply(pat(4), 10);
    chk("t6_next_pos", 32'(pos), 32'h1);
    chk("t6_next_steps", 32'(n_step - s0), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Monitor/decoder for the four stepping-motor coil drive signals (A+, B+, A-, B-).
- Reconstructs electrical step index, direction, signed half-step position, step period and stall status from the phase pattern.
- Sits on the motor-control outputs, or on external sense lines, for closed-loop checking and position readback.
- Flags illegal patterns and illegal transitions.

Parameters:
- POS_W, 16, width of signed position counter (half-step units)
- PER_W, 24, width of step-period counter (clk cycles)
- STALL_CNT, 24'd5000000, clk cycles without a step before stalled asserts (100 ms at 50 MHz)

Ports:
- clk  in  1  system clock (50 MHz)
- xres  in  1  reset, asynchronous, active-low
- ph_ap  in  1  A+ phase drive
- ph_bp  in  1  B+ phase drive
- ph_an  in  1  A- phase drive
- ph_bn  in  1  B- phase drive
- clr  in  1  synchronous clear of pos and err
- pos  out  POS_W  signed position, half-steps, two's complement
- dir  out  1  direction of last step: 1 = cw, 0 = ccw
- step_pulse  out  1  one-cycle pulse per decoded step event
- period  out  PER_W  clk cycles between the last two step events
- period_vld  out  1  one-cycle pulse when period is updated
- stalled  out  1  no step for STALL_CNT cycles
- err  out  1  sticky illegal pattern/transition flag

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low; ports are named clk and xres.
- Reset values:
  - pos = 0, dir = 1, step_pulse = 0, period = 0, period_vld = 0, stalled = 1, err = 0.
  - Internal state: ref_vld = 0, period counter = 0, have_prev = 0.
- Input stage: each phase input passes through a 2-flop synchronizer, giving ph_s = {ap, bp, an, bn}.
- Index map for ph_s:
  - 1000 → 0, 1100 → 1, 0100 → 2, 0110 → 3, 0010 → 4, 0011 → 5, 0001 → 6, 1001 → 7.
  - cw = increasing index mod 8.
- Idle pattern 0000: no event; ref_idx is retained.
- Illegal pattern (1010, 0101, or any pattern with 3 or 4 bits set): err <= 1, no step, ref_idx retained.
- Step evaluation, on a valid pattern with ref_vld = 1 and new_idx != ref_idx:
  - d = (new_idx - ref_idx) mod 8.
  - d = 1 or 2: cw step; pos += d; dir <= 1.
  - d = 7 or 6: ccw step; pos -= (8 - d); dir <= 0.
  - d = 3, 4 or 5: err <= 1; no pos change; ref_idx <= new_idx.
  - Legal step: ref_idx <= new_idx; step_pulse = 1 for one cycle.
- First valid pattern after reset (ref_vld = 0): load ref_idx, set ref_vld; no step, no pos change.
- Latency: step_pulse and the pos/dir update are registered 3 clk after the input edge (2 sync + 1 decode).
- Same index repeated: no event.
- Period measurement:
  - Counter increments every cycle and saturates at all-ones.
  - On a step: if have_prev = 1, period <= cnt + 1 (saturating) and period_vld pulses. Then cnt <= 0 and have_prev <= 1.
  - The first step after reset or after a stall produces no period_vld.
- Stall:
  - When cnt reaches STALL_CNT: stalled <= 1, have_prev <= 0.
  - Any step: stalled <= 0 in the same cycle as step_pulse.
- clr:
  - pos <= 0 and err <= 0; ref_idx, period and stall state are unaffected.
  - clr coincident with a step: pos <= 0 (the step increment is dropped); step_pulse, dir and period update normally.
  - clr coincident with an illegal event: err <= 1 (the error wins).
- pos wraps two's complement: 0x7FFF + 1 → 0x8000; 0x8000 - 1 → 0x7FFF.
- Reset mid-stream: all state returns to reset values immediately; decoding restarts with a reference load.

Decomposition:
- Package stepper_pkg holds:
  - phase pattern constants (PH_IDLE and the 8 valid patterns);
  - IDX_W = 3;
  - function ph2idx (returns valid flag + index);
  - direction constants DIR_CW = 1, DIR_CCW = 0.
- Sub-module phase_sync: parameterised-width 2-flop synchronizer with clk/xres, reset value 0, instantiated once with width 4.

Test Plan:
- 2-phase cw: 1100 → 0110 → 0011 → 1001 → 1100, each held 100 clk → pos 0, 2, 4, 6, 8 (first pattern only loads the reference); dir = 1; 4 step_pulse; period_vld on steps 2–4 with period = 100.
- 1-2 phase ccw: 1000 → 1001 → 0001 → 0011, 50 clk each → pos 0, -1, -2, -3; dir = 0; period = 50.
- Illegal patterns: apply 1010 → err = 1, pos unchanged. Apply the jump 1000 → 0010 (d = 4) → err = 1, no step_pulse. Pulse clr → err = 0, pos = 0.
- Stall, with STALL_CNT = 200: step once, hold 250 clk → stalled = 1 at cnt = 200. Next step → stalled = 0, no period_vld. Following step after 30 clk → period = 30.
- Wrap and coincident clr: preload pos to 0x7FFF via a cw step sequence (POS_W = 8 build: 127) → next +1 step gives -128. Assert clr in the same cycle as a step → pos = 0, step_pulse = 1.
- Async reset mid-sequence: drop xres between steps → all outputs return to reset values immediately. After release, the first pattern produces no step.
